// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared widths, window slot offsets and FSM encoding for the 3x3 filter scan
package filter_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 72;
  localparam int DEPTH = 10000;

  // Bit offsets of each 8-bit slot inside the window bus (p00 = top-left, MSB first)
  localparam int P00 = 64;
  localparam int P01 = 56;
  localparam int P02 = 48;
  localparam int P10 = 40;
  localparam int P11 = 32;
  localparam int P12 = 24;
  localparam int P20 = 16;
  localparam int P21 = 8;
  localparam int P22 = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/filter_scan_ctrl_if.sv
// rtl/filter_scan_ctrl_if.sv - handshake, source RAM, window and result RAM signals of the scan controller
interface filter_scan_ctrl_if
  import filter_pkg::*;
#(
  parameter int AW = 14
);

  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic [WIN_W-1:0] win_bus;
  logic             win_valid;
  logic [PIX_W-1:0] filt_in;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [PIX_W-1:0] wr_data;

  // Environment side: issues start, supplies source pixels and filter results
  modport master (
    output start, rd_data, filt_in,
    input  busy, done, rd_en, rd_addr, win_bus, win_valid, wr_en, wr_addr, wr_data
  );

  // Controller side
  modport slave (
    input  start, rd_data, filt_in,
    output busy, done, rd_en, rd_addr, win_bus, win_valid, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/scan_line_buf.sv
// rtl/scan_line_buf.sv - one image row of pixels, one write and one combinational read per cycle
module scan_line_buf
  import filter_pkg::*;
#(
  parameter int LEN = 100,
  parameter int LAW = $clog2(LEN)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [LAW-1:0]   wr_addr_i,
  input  logic [PIX_W-1:0] wr_data_i,
  input  logic [LAW-1:0]   rd_addr_i,
  output logic [PIX_W-1:0] rd_data_o
);

  logic [PIX_W-1:0] mem_q [LEN];

  // Store the column's pixel; a same-cycle read still returns the previous row's value
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/filter_scan_ctrl.sv
// rtl/filter_scan_ctrl.sv - raster-scan sequencer building 3x3 windows and writing filtered pixels
module filter_scan_ctrl
  import filter_pkg::*;
#(
  parameter int IMG_W    = 100,
  parameter int IMG_H    = 100,
  parameter int AW       = 14,
  parameter int FILT_LAT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  filter_scan_ctrl_if.slave    bus
);

  localparam int            CW        = $clog2(IMG_W);
  localparam int            RW        = $clog2(IMG_H);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] CTR_OFS   = AW'(IMG_W + 1);

  state_t           state_q;
  logic             busy_q, done_q, rd_en_q;
  logic [AW-1:0]    rd_addr_q;

  logic             pix_vld_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [AW-1:0]    pix_addr_q;
  logic [WIN_W-1:0] win_q, win_d;

  logic [FILT_LAT:0] vld_q;
  logic [AW-1:0]     ctr_q [FILT_LAT+1];
  logic              wr_en_q;
  logic [AW-1:0]     wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;

  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic             interior, pipe_busy;

  assign interior  = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign pipe_busy = pix_vld_q | (|vld_q);

  scan_line_buf #(.LEN(IMG_W)) u_lb0 (
    .clk_i     (clk_i),
    .wr_en_i   (pix_vld_q),
    .wr_addr_i (col_q),
    .wr_data_i (bus.rd_data),
    .rd_addr_i (col_q),
    .rd_data_o (lb0_rd)
  );

  scan_line_buf #(.LEN(IMG_W)) u_lb1 (
    .clk_i     (clk_i),
    .wr_en_i   (pix_vld_q),
    .wr_addr_i (col_q),
    .wr_data_i (lb0_rd),
    .rd_addr_i (col_q),
    .rd_data_o (lb1_rd)
  );

  // Frame sequencing: issue one read per cycle, then wait for the write pipeline to empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q   <= READ;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        READ: begin
          if (rd_addr_q == LAST_ADDR) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        DRAIN: begin
          if (!pipe_busy) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Window shifts left; the new right column is {two rows up, one row up, returning pixel}
  always_comb begin
    win_d           = win_q;
    win_d[P00 +: 8] = win_q[P01 +: 8];
    win_d[P01 +: 8] = win_q[P02 +: 8];
    win_d[P02 +: 8] = lb1_rd;
    win_d[P10 +: 8] = win_q[P11 +: 8];
    win_d[P11 +: 8] = win_q[P12 +: 8];
    win_d[P12 +: 8] = lb0_rd;
    win_d[P20 +: 8] = win_q[P21 +: 8];
    win_d[P21 +: 8] = win_q[P22 +: 8];
    win_d[P22 +: 8] = bus.rd_data;
  end

  // Pixel stage: absorb returning pixels and track their row/column/address
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_vld_q  <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      pix_addr_q <= '0;
      win_q      <= '0;
    end else begin
      pix_vld_q <= rd_en_q;
      if (state_q == IDLE && bus.start) begin
        col_q      <= '0;
        row_q      <= '0;
        pix_addr_q <= '0;
      end else if (pix_vld_q) begin
        win_q      <= win_d;
        pix_addr_q <= pix_addr_q + AW'(1);
        if (col_q == CW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  // Window valid and centre address ride alongside the filter latency, then register the write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q     <= '0;
      for (int k = 0; k <= FILT_LAT; k++) ctr_q[k] <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      vld_q[0] <= pix_vld_q && interior;
      ctr_q[0] <= pix_addr_q - CTR_OFS;
      for (int k = 1; k <= FILT_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        ctr_q[k] <= ctr_q[k-1];
      end
      wr_en_q <= vld_q[FILT_LAT];
      if (vld_q[FILT_LAT]) begin
        wr_addr_q <= ctr_q[FILT_LAT];
        wr_data_q <= bus.filt_in;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.win_bus   = win_q;
  assign bus.win_valid = vld_q[0];
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// tb/tb_filter_scan_ctrl.sv - directed bench for filter_scan_ctrl over three image/latency configurations
module tb_filter_scan_ctrl;

  localparam int NI = 3;
  localparam int AW = 14;
  localparam int PW  [NI] = '{5, 5, 3};
  localparam int PH  [NI] = '{4, 4, 3};
  localparam int PFL [NI] = '{2, 0, 5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]          start_v, rst_v, busy_v, done_v, rd_en_v, win_valid_v, wr_en_v;
  logic [NI-1:0][AW-1:0]  rd_addr_v, wr_addr_v;
  logic [NI-1:0][7:0]     wr_data_v;
  logic [NI-1:0][71:0]    win_bus_v;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    filter_scan_ctrl_if #(.AW(AW)) bus ();
    logic [7:0] cpipe [8];

    assign bus.start      = start_v[g];
    assign busy_v[g]      = bus.busy;
    assign done_v[g]      = bus.done;
    assign rd_en_v[g]     = bus.rd_en;
    assign rd_addr_v[g]   = bus.rd_addr;
    assign win_valid_v[g] = bus.win_valid;
    assign win_bus_v[g]   = bus.win_bus;
    assign wr_en_v[g]     = bus.wr_en;
    assign wr_addr_v[g]   = bus.wr_addr;
    assign wr_data_v[g]   = bus.wr_data;

    filter_scan_ctrl #(.IMG_W(PW[g]), .IMG_H(PH[g]), .AW(AW), .FILT_LAT(PFL[g])) u_dut (
      .clk_i (clk),
      .rst_i (rst_v[g]),
      .bus   (bus)
    );

    // Source RAM: pixel value is the low byte of its address, one-cycle read latency
    always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];
    end

    // Filter: centre passthrough delayed by the configured latency
    always @(posedge clk) begin
      cpipe[0] <= bus.win_bus[39:32];
      for (int k = 1; k < 8; k++) cpipe[k] <= cpipe[k-1];
    end

    if (PFL[g] == 0) begin : g_f0
      assign bus.filt_in = bus.win_bus[39:32];
    end else begin : g_fn
      assign bus.filt_in = cpipe[PFL[g]-1];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_rd [NI], n_win [NI], n_wr [NI], n_done [NI], last_rd [NI], last_wr [NI];
  int winq [NI][$];
  bit wrote [NI][32];
  logic [71:0] first_win [NI];
  int first_wr [NI], last_wr_addr [NI];

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int g, input int k);
    int w = PW[g];
    int r = k / (w - 2) + 2;
    int c = k % (w - 2) + 2;
    logic [71:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v = {v[63:0], 8'((r - 2 + i) * w + c - 2 + j)};
    return v;
  endfunction

  function automatic int exp_ctr(input int g, input int k);
    int w = PW[g];
    return (k / (w - 2) + 1) * w + k % (w - 2) + 1;
  endfunction

  task automatic reset_mon(input int g);
    n_rd[g] = 0; n_win[g] = 0; n_wr[g] = 0;
    winq[g].delete();
    for (int a = 0; a < 32; a++) wrote[g][a] = 1'b0;
  endtask

  task automatic monitor();
    for (int g = 0; g < NI; g++) begin
      int w = PW[g];
      int h = PH[g];
      int fl = PFL[g];
      int nw = (w - 2) * (h - 2);
      if (rd_en_v[g] === 1'b1) begin
        check($sformatf("g%0d rd_addr", g), 72'(rd_addr_v[g]), 72'(n_rd[g]));
        n_rd[g]++;
        last_rd[g] = cyc;
      end
      if (win_valid_v[g] === 1'b1) begin
        if (n_win[g] == 0) first_win[g] = win_bus_v[g];
        check($sformatf("g%0d win_bus", g), win_bus_v[g], exp_win(g, n_win[g]));
        winq[g].push_back(cyc);
        n_win[g]++;
      end
      if (wr_en_v[g] === 1'b1) begin
        int ea = exp_ctr(g, n_wr[g]);
        if (winq[g].size() == 0) begin
          check($sformatf("g%0d wr_orphan", g), 72'(1), 72'(0));
        end else begin
          int t = winq[g].pop_front();
          check($sformatf("g%0d wr_lat", g), 72'(cyc - t), 72'(fl + 1));
        end
        check($sformatf("g%0d wr_addr", g), 72'(wr_addr_v[g]), 72'(ea));
        check($sformatf("g%0d wr_data", g), 72'(wr_data_v[g]), 72'(ea & 255));
        if (n_wr[g] == 0) first_wr[g] = int'(wr_addr_v[g]);
        last_wr_addr[g] = int'(wr_addr_v[g]);
        if (wr_addr_v[g] < 32) wrote[g][wr_addr_v[g][4:0]] = 1'b1;
        n_wr[g]++;
        last_wr[g] = cyc;
      end
      if (done_v[g] === 1'b1) begin
        check($sformatf("g%0d done_after_wr", g), 72'(cyc - last_wr[g]), 72'(1));
        check($sformatf("g%0d done_after_rd", g), 72'(cyc - last_rd[g]), 72'(4 + fl));
        check($sformatf("g%0d busy_at_done", g), 72'(busy_v[g]), 72'(1));
        check($sformatf("g%0d n_rd", g), 72'(n_rd[g]), 72'(w * h));
        check($sformatf("g%0d n_win", g), 72'(n_win[g]), 72'(nw));
        check($sformatf("g%0d n_wr", g), 72'(n_wr[g]), 72'(nw));
        for (int a = 0; a < w * h; a++) begin
          bit inner = (a / w >= 1) && (a / w <= h - 2) && (a % w >= 1) && (a % w <= w - 2);
          check($sformatf("g%0d written[%0d]", g, a), 72'(wrote[g][a]), 72'(inner));
        end
        n_done[g]++;
        reset_mon(g);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic run_frames(input logic [NI-1:0] mask);
    int d0 [NI];
    int cnt = 0;
    bit all_done;
    for (int g = 0; g < NI; g++) d0[g] = n_done[g];
    start_v = mask;
    step();
    start_v = '0;
    while (cnt < 300) begin
      all_done = 1'b1;
      for (int g = 0; g < NI; g++)
        if (mask[g] && n_done[g] == d0[g]) all_done = 1'b0;
      if (all_done) break;
      step();
      cnt++;
    end
    for (int g = 0; g < NI; g++)
      if (mask[g]) check($sformatf("g%0d frame_done", g), 72'(n_done[g] - d0[g]), 72'(1));
    step();
  endtask

  initial begin
    int d, cnt, dprev;
    bit prev_done;

    start_v = '0;
    rst_v   = '1;
    for (int g = 0; g < NI; g++) begin
      n_done[g] = 0; last_rd[g] = 0; last_wr[g] = 0;
      reset_mon(g);
    end
    repeat (3) step();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("g%0d rst_strobes", g),
            72'({busy_v[g], done_v[g], rd_en_v[g], win_valid_v[g], wr_en_v[g]}), 72'(0));
      check($sformatf("g%0d rst_rd_addr", g), 72'(rd_addr_v[g]), 72'(0));
      check($sformatf("g%0d rst_wr_addr", g), 72'(wr_addr_v[g]), 72'(0));
      check($sformatf("g%0d rst_wr_data", g), 72'(wr_data_v[g]), 72'(0));
      check($sformatf("g%0d rst_win_bus", g), win_bus_v[g], 72'(0));
    end
    rst_v = '0;
    step();

    // One frame on every configuration
    run_frames('1);
    check("t1_first_win", first_win[0], 72'h00_01_02_05_06_07_0A_0B_0C);
    check("t1_first_wr", 72'(first_wr[0]), 72'(6));
    check("t1_last_wr", 72'(last_wr_addr[0]), 72'(13));
    check("t5_first_wr", 72'(first_wr[1]), 72'(6));
    check("t6_first_win", first_win[2], 72'h00_01_02_03_04_05_06_07_08);
    check("t6_wr_addr", 72'(first_wr[2]), 72'(4));
    check("t6_last_wr", 72'(last_wr_addr[2]), 72'(4));

    // start held high: back-to-back frames, one idle cycle between them
    d = n_done[0];
    cnt = 0;
    prev_done = 1'b0;
    dprev = -1;
    start_v[0] = 1'b1;
    while (n_done[0] < d + 3 && cnt < 200) begin
      step();
      cnt++;
      if (prev_done) check("t3_gap_busy", 72'(busy_v[0]), 72'(0));
      if (done_v[0] === 1'b1) begin
        if (dprev >= 0) check("t3_period", 72'(cyc - dprev), 72'(27));
        dprev = cyc;
      end
      prev_done = done_v[0];
    end
    start_v[0] = 1'b0;
    check("t3_dones", 72'(n_done[0] - d), 72'(3));
    step();
    step();
    check("t3_idle_busy", 72'(busy_v[0]), 72'(0));

    // Reset in the middle of READ, with windows and writes in flight
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (15) step();
    check("t4_active", 72'({busy_v[0], rd_en_v[0]}), 72'(3));
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    check("t4_strobes", 72'({rd_en_v[0], wr_en_v[0], win_valid_v[0], busy_v[0], done_v[0]}), 72'(0));
    reset_mon(0);
    repeat (8) step();
    check("t4_quiet", 72'(n_wr[0] + n_rd[0] + n_win[0]), 72'(0));
    run_frames(3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
